l2_cache_responder: RTL and testbench
=====================================

L2_CACHE_RESPONDER -- requirements
Module: l2_cache_responder

Interface
REQ-001 SHALL have parameter WAY, default 8, associativity (power of two, >=2).
REQ-002 SHALL have parameter BLOCK_SIZE_BYTE, default 16, line size.
REQ-003 SHALL have parameter CACHE_SIZE_BYTE, default 262144, capacity; SETS = CACHE_SIZE_BYTE/(BLOCK_SIZE_BYTE*WAY), OFF_W = log2(BLOCK_SIZE_BYTE), IDX_W = log2(SETS), TAG_W = 32-IDX_W-OFF_W.
REQ-004 SHALL have port clk  input  1  the single clock, all state on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port find_start  input  1  L1 miss request strobe, sampled only in IDLE.
REQ-007 SHALL have port addr  input  32  request address, captured with find_start.
REQ-008 SHALL have port done_L2  output  1  one-cycle completion pulse.
REQ-009 SHALL have port L2_cache_hit  output  1  lookup result, valid from done_L2 until next accepted request.
REQ-010 SHALL have port back_invalidation  output  1  an inclusive eviction requires L1 to drop a line.
REQ-011 SHALL have port back_invalidation_data  output  32  evicted line address {victim_tag, index, OFF_W'b0}.
REQ-012 SHALL have ports cache_hit_count and cache_miss_count  output  20 each  saturating statistics.

Function
REQ-013 SHALL store per set WAY lines of {valid, tag}, way 0 = MRU, way WAY-1 = LRU.
REQ-014 SHALL implement states IDLE, LOOKUP, UPDATE, DONE; IDLE->LOOKUP on find_start, capturing addr; LOOKUP->UPDATE always; UPDATE->DONE when shifting completes; DONE->IDLE always.
REQ-015 LOOKUP SHALL compare all valid ways of the set in one cycle; multiple matches SHALL resolve to the lowest way.
REQ-016 On hit in way h, UPDATE SHALL shift ways h-1..0 down by one, one way per cycle, then write the hit line to way 0 (h+1 UPDATE cycles).
REQ-017 On miss, UPDATE SHALL behave as h = WAY-1 and insert {1, tag} at way 0, discarding the former LRU line.
REQ-018 done_L2 SHALL assert exactly 3+h cycles after the find_start sampling edge (miss: WAY+2), for exactly one cycle, in DONE.
REQ-019 L2_cache_hit, back_invalidation and back_invalidation_data SHALL be updated at the end of LOOKUP and held stable until the next accepted find_start, when back_invalidation clears.
REQ-020 back_invalidation SHALL be 1 only on a miss whose LRU victim was valid; otherwise 0 and back_invalidation_data = 0.
REQ-021 find_start outside IDLE SHALL be ignored, with no queuing.
REQ-022 Counters SHALL increment once per request in LOOKUP and saturate at 20'hFFFFF.

Reset
REQ-023 reset low SHALL immediately force state IDLE, all valid bits 0, all outputs and counters 0, including mid-UPDATE; the interrupted request is dropped.

Configuration
REQ-024 With L2_BACK_INVALIDATION_EN defined, REQ-020 SHALL apply (inclusive L2).
REQ-025 Without it, back_invalidation and back_invalidation_data SHALL be constant 0 (non-inclusive), all other behaviour unchanged.

Structure
REQ-026 A shared package cache_pkg SHALL hold the state enum, the line-entry typedef and the size-derivation functions.
REQ-027 A combinational sub-module cache_way_match SHALL perform tag compare and lowest-way priority encode, returning hit and hit_way.

Verification
REQ-028 After reset, request 0x0000_1000 -> done_L2 10 cycles later, L2_cache_hit=0, back_invalidation=0, miss_count=1.
REQ-029 Repeat 0x0000_1000 -> hit in way 0, done_L2 after 3 cycles, hit_count=1.
REQ-030 Miss A=0x1000, B=0x9000, C=0x11000, D=0x19000 (same set), then A -> hit way 3, done after 6 cycles; A again -> done after 3.
REQ-031 Nine distinct tags to set 0x100 (stride 0x8000, starting 0x1000) -> ninth miss gives back_invalidation=1, data=0x0000_1000; same test without the macro -> back_invalidation=0.
REQ-032 find_start pulsed every cycle during a miss -> exactly one done_L2 per accepted request; reset asserted mid-UPDATE -> all outputs 0 at once, next access to 0x1000 misses.

Source files
------------

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and size helpers for the L2 responder
package cache_pkg;

  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE, DONE} state_t;

  // Tag field is sized for the widest possible tag; unused upper bits stay zero.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] tag;
  } line_t;

  function automatic int log2_of(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int sets_of(input int cache_bytes, input int block_bytes, input int ways);
    return cache_bytes / (block_bytes * ways);
  endfunction

  function automatic int tag_w_of(input int cache_bytes, input int block_bytes, input int ways);
    return ADDR_W - log2_of(sets_of(cache_bytes, block_bytes, ways)) - log2_of(block_bytes);
  endfunction

endpackage

// File: rtl/cache_way_match.sv
// rtl/cache_way_match.sv - per-set tag compare with lowest-way priority
module cache_way_match
  import cache_pkg::*;
#(
  parameter int WAY   = 8,
  parameter int WAY_W = 3
) (
  input  line_t                    lines [WAY],
  input  logic [ADDR_W-1:0]        tag,
  output logic                     hit,
  output logic [WAY_W-1:0]         hit_way
);

  // Scanning downward lets the lowest matching way win.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = WAY - 1; w >= 0; w--) begin
      if (lines[w].valid && (lines[w].tag == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

endmodule

// File: rtl/l2_cache_responder.sv
// rtl/l2_cache_responder.sv - LRU-ordered L2 tag lookup; L2_BACK_INVALIDATION_EN enables inclusive back-invalidation
module l2_cache_responder
  import cache_pkg::*;
#(
  parameter int WAY             = 8,
  parameter int BLOCK_SIZE_BYTE = 16,
  parameter int CACHE_SIZE_BYTE = 262144
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        find_start,
  input  logic [31:0] addr,
  output logic        done_L2,
  output logic        L2_cache_hit,
  output logic        back_invalidation,
  output logic [31:0] back_invalidation_data,
  output logic [19:0] cache_hit_count,
  output logic [19:0] cache_miss_count
);

  localparam int SETS  = sets_of(CACHE_SIZE_BYTE, BLOCK_SIZE_BYTE, WAY);
  localparam int OFF_W = log2_of(BLOCK_SIZE_BYTE);
  localparam int IDX_W = log2_of(SETS);
  localparam int TAG_W = tag_w_of(CACHE_SIZE_BYTE, BLOCK_SIZE_BYTE, WAY);
  localparam int WAY_W = log2_of(WAY);

  state_t            state, state_next;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WAY_W-1:0]  shift_pos;
  line_t             mem [SETS][WAY];
  line_t             set_lines [WAY];
  logic              match_hit;
  logic [WAY_W-1:0]  match_way;
  logic [ADDR_W-1:0] req_tag_ext;
  logic              unused_off;

  assign req_tag_ext = ADDR_W'(req_tag);
  assign unused_off  = ^addr[OFF_W-1:0];

  always_comb begin
    for (int w = 0; w < WAY; w++) set_lines[w] = mem[req_idx][w];
  end

  cache_way_match #(.WAY(WAY), .WAY_W(WAY_W)) u_match (
    .lines   (set_lines),
    .tag     (req_tag_ext),
    .hit     (match_hit),
    .hit_way (match_way)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    done_L2    = 1'b0;
    case (state)
      IDLE:    if (find_start) state_next = LOOKUP;
      LOOKUP:  state_next = UPDATE;
      UPDATE:  if (shift_pos == '0) state_next = DONE;
      DONE: begin
        done_L2    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // shift_pos walks from the hit way (or LRU on a miss) down to 0, moving one line per cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_tag          <= '0;
      req_idx          <= '0;
      shift_pos        <= '0;
      L2_cache_hit     <= 1'b0;
      cache_hit_count  <= '0;
      cache_miss_count <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAY; w++) mem[s][w] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (find_start) begin
            req_tag <= addr[31 -: TAG_W];
            req_idx <= addr[OFF_W +: IDX_W];
          end
        end
        LOOKUP: begin
          L2_cache_hit <= match_hit;
          if (match_hit) begin
            shift_pos <= match_way;
            if (cache_hit_count != 20'hFFFFF) cache_hit_count <= cache_hit_count + 20'd1;
          end else begin
            shift_pos <= WAY_W'(WAY - 1);
            if (cache_miss_count != 20'hFFFFF) cache_miss_count <= cache_miss_count + 20'd1;
          end
        end
        UPDATE: begin
          if (shift_pos != '0) begin
            mem[req_idx][shift_pos] <= mem[req_idx][shift_pos - WAY_W'(1)];
            shift_pos               <= shift_pos - WAY_W'(1);
          end else begin
            mem[req_idx][0] <= '{valid: 1'b1, tag: req_tag_ext};
          end
        end
        default: ;
      endcase
    end
  end

`ifdef L2_BACK_INVALIDATION_EN
  logic        bi_q;
  logic [31:0] bi_data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bi_q      <= 1'b0;
      bi_data_q <= '0;
    end else if (state == IDLE && find_start) begin
      bi_q      <= 1'b0;
      bi_data_q <= '0;
    end else if (state == LOOKUP) begin
      if (!match_hit && set_lines[WAY-1].valid) begin
        bi_q      <= 1'b1;
        bi_data_q <= {set_lines[WAY-1].tag[TAG_W-1:0], req_idx, {OFF_W{1'b0}}};
      end else begin
        bi_q      <= 1'b0;
        bi_data_q <= '0;
      end
    end
  end

  assign back_invalidation      = bi_q;
  assign back_invalidation_data = bi_data_q;
`else
  assign back_invalidation      = 1'b0;
  assign back_invalidation_data = '0;
`endif

endmodule

// File: tb/tb_l2_cache_responder.sv
// tb/tb_l2_cache_responder.sv - directed bench for l2_cache_responder
module tb_l2_cache_responder;

  logic        clk;
  logic        reset;
  logic        find_start;
  logic [31:0] addr;
  logic        done_L2;
  logic        L2_cache_hit;
  logic        back_invalidation;
  logic [31:0] back_invalidation_data;
  logic [19:0] cache_hit_count;
  logic [19:0] cache_miss_count;

  int errors = 0;
  int checks = 0;

  l2_cache_responder dut (
    .clk                    (clk),
    .reset                  (reset),
    .find_start             (find_start),
    .addr                   (addr),
    .done_L2                (done_L2),
    .L2_cache_hit           (L2_cache_hit),
    .back_invalidation      (back_invalidation),
    .back_invalidation_data (back_invalidation_data),
    .cache_hit_count        (cache_hit_count),
    .cache_miss_count       (cache_miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Latency counts negedges after the sampling edge; the Nth negedge lies in cycle N.
  task automatic do_req(input logic [31:0] a, output int lat, output logic bi_acc);
    @(negedge clk);
    find_start = 1'b1;
    addr       = a;
    @(negedge clk);
    find_start = 1'b0;
    bi_acc     = back_invalidation;
    lat        = 1;
    while (!done_L2 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic all_zero(input string tag);
    check({tag, "_done"},  {31'd0, done_L2}, 32'd0);
    check({tag, "_hit"},   {31'd0, L2_cache_hit}, 32'd0);
    check({tag, "_bi"},    {31'd0, back_invalidation}, 32'd0);
    check({tag, "_bid"},   back_invalidation_data, 32'd0);
    check({tag, "_hcnt"},  {12'd0, cache_hit_count}, 32'd0);
    check({tag, "_mcnt"},  {12'd0, cache_miss_count}, 32'd0);
  endtask

  logic [31:0] exp_bi_on;
  int          lat;
  logic        bi_acc;
  int          dones;
  int          first_done;

  initial begin
`ifdef L2_BACK_INVALIDATION_EN
    exp_bi_on = 32'd1;
`else
    exp_bi_on = 32'd0;
`endif
    reset      = 1'b1;
    find_start = 1'b0;
    addr       = '0;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    all_zero("reset");
    reset = 1'b1;

    do_req(32'h0000_1000, lat, bi_acc);
    check("first_miss_lat", lat, 32'd10);
    check("first_miss_hit", {31'd0, L2_cache_hit}, 32'd0);
    check("first_miss_bi", {31'd0, back_invalidation}, 32'd0);
    check("first_miss_cnt", {12'd0, cache_miss_count}, 32'd1);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done_L2}, 32'd0);

    do_req(32'h0000_1000, lat, bi_acc);
    check("hit_way0_lat", lat, 32'd3);
    check("hit_way0_hit", {31'd0, L2_cache_hit}, 32'd1);
    check("hit_way0_cnt", {12'd0, cache_hit_count}, 32'd1);

    do_req(32'h0000_9000, lat, bi_acc);
    check("miss_b_lat", lat, 32'd10);
    do_req(32'h0001_1000, lat, bi_acc);
    do_req(32'h0001_9000, lat, bi_acc);
    check("miss_d_hit", {31'd0, L2_cache_hit}, 32'd0);
    do_req(32'h0000_1000, lat, bi_acc);
    check("hit_way3_lat", lat, 32'd6);
    check("hit_way3_hit", {31'd0, L2_cache_hit}, 32'd1);
    do_req(32'h0000_1000, lat, bi_acc);
    check("hit_mru_lat", lat, 32'd3);
    check("hits_total", {12'd0, cache_hit_count}, 32'd3);
    check("misses_total", {12'd0, cache_miss_count}, 32'd4);

    // Fill set 0x100 from a clean cache, then force one eviction.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      do_req(32'h0000_1000 + 32'h8000 * i, lat, bi_acc);
    end
    check("eighth_miss_bi", {31'd0, back_invalidation}, 32'd0);
    check("eighth_miss_bid", back_invalidation_data, 32'd0);
    do_req(32'h0004_1000, lat, bi_acc);
    check("ninth_miss_lat", lat, 32'd10);
    check("ninth_miss_bi", {31'd0, back_invalidation}, exp_bi_on);
    check("ninth_miss_bid", back_invalidation_data, exp_bi_on * 32'h0000_1000);
    check("ninth_miss_cnt", {12'd0, cache_miss_count}, 32'd9);
    do_req(32'h0000_1000, lat, bi_acc);
    check("bi_clear_on_accept", {31'd0, bi_acc}, 32'd0);
    check("evicted_line_miss", {31'd0, L2_cache_hit}, 32'd0);
    check("second_evict_bid", back_invalidation_data, exp_bi_on * 32'h0000_9000);

    // find_start held high across a whole miss.
    @(negedge clk);
    find_start = 1'b1;
    addr       = 32'h0000_2000;
    dones      = 0;
    first_done = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done_L2) begin
        dones++;
        if (first_done == 0) first_done = i;
        find_start = 1'b0;
      end
    end
    find_start = 1'b0;
    check("busy_ignore_dones", dones, 32'd1);
    check("busy_ignore_lat", first_done, 32'd10);
    check("busy_ignore_misses", {12'd0, cache_miss_count}, 32'd11);
    do_req(32'h0000_2000, lat, bi_acc);
    check("busy_line_hit_lat", lat, 32'd3);

    // Reset in the middle of a way-7 hit update.
    @(negedge clk);
    find_start = 1'b1;
    addr       = 32'h0001_1000;
    @(negedge clk);
    find_start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_update_hit", {31'd0, L2_cache_hit}, 32'd1);
    check("mid_update_hcnt", {12'd0, cache_hit_count}, 32'd2);
    reset = 1'b0;
    #1;
    all_zero("mid_reset");
    @(negedge clk);
    reset = 1'b1;
    do_req(32'h0000_1000, lat, bi_acc);
    check("post_reset_lat", lat, 32'd10);
    check("post_reset_hit", {31'd0, L2_cache_hit}, 32'd0);
    check("post_reset_mcnt", {12'd0, cache_miss_count}, 32'd1);
    check("post_reset_bi", {31'd0, back_invalidation}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
